// File: rtl/cfu_mac_sequencer_if.sv
// Handshake bundle between the MAC sequencer and its start/buffer/weight/quantizer/result partners.
// The master side is the surrounding CFU environment; the sequencer connects through the slave modport.
interface cfu_mac_sequencer_if #(
    parameter int LEN_W = 9
);
    logic                     start_valid;
    logic                     start_ready;
    logic [LEN_W-1:0]         start_len;
    logic signed [31:0]       offset;
    logic                     abort;
    logic                     buf_read_valid;
    logic [31:0]              buf_read_data;
    logic                     buf_read_en;
    logic                     buf_write_en;
    logic [31:0]              buf_write_data;
    logic                     wgt_valid;
    logic [31:0]              wgt_data;
    logic                     wgt_ready;
    logic signed [31:0]       qnt_data_in;
    logic                     qnt_start;
    logic                     qnt_status;
    logic [31:0]              qnt_out;
    logic                     res_valid;
    logic                     res_ready;
    logic [31:0]              res_data;
    logic                     res_error;
    logic                     busy;

    modport master (
        output start_valid, start_len, offset, abort,
        output buf_read_valid, buf_read_data, wgt_valid, wgt_data,
        output qnt_status, qnt_out, res_ready,
        input  start_ready, buf_read_en, buf_write_en, buf_write_data, wgt_ready,
        input  qnt_data_in, qnt_start, res_valid, res_data, res_error, busy
    );

    modport slave (
        input  start_valid, start_len, offset, abort,
        input  buf_read_valid, buf_read_data, wgt_valid, wgt_data,
        input  qnt_status, qnt_out, res_ready,
        output start_ready, buf_read_en, buf_write_en, buf_write_data, wgt_ready,
        output qnt_data_in, qnt_start, res_valid, res_data, res_error, busy
    );
endinterface

// File: rtl/cfu_mac_sequencer.sv
// Runs one output element: LEN offset int8x4 dot products from buffer and weight streams,
// then a quantizer round trip with timeout, returning the result through a valid/ready port.
module cfu_mac_sequencer #(
    parameter int LEN_W       = 9,
    parameter int QNT_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    cfu_mac_sequencer_if.slave bus
);
    localparam int TMO_W = $clog2(QNT_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RUN, QSTART, QWAIT, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   count;
    logic signed [31:0] offset_r;
    logic signed [31:0] acc;
    logic [TMO_W-1:0]   tmo;
    logic [31:0]        res_data_r;
    logic               res_error_r;
    logic               beat;
    logic               last_beat;
    logic               tmo_hit;

    function automatic logic signed [31:0] lane_sext(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    // Wrapping 32-bit accumulate of the four offset-activation x weight lane products.
    function automatic logic signed [31:0] dot4(input logic [31:0] a, input logic [31:0] w,
                                               input logic signed [31:0] off);
        logic signed [31:0] sum;
        sum = '0;
        for (int i = 0; i < 4; i++)
            sum = sum + (lane_sext(a[8*i +: 8]) + off) * lane_sext(w[8*i +: 8]);
        return sum;
    endfunction

    assign beat      = (state == RUN) && bus.buf_read_valid && bus.wgt_valid && !bus.abort;
    assign last_beat = beat && (count == len_r - LEN_W'(1));
    assign tmo_hit   = (tmo == TMO_W'(QNT_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start_valid) state_nxt = (bus.start_len == '0) ? QSTART : RUN;
                RUN:     if (last_beat) state_nxt = QSTART;
                QSTART:  state_nxt = QWAIT;
                QWAIT:   if (bus.qnt_status || tmo_hit) state_nxt = DONE;
                DONE:    if (bus.res_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.start_ready    = (state == IDLE);
        bus.busy           = (state != IDLE);
        bus.qnt_start      = (state == QSTART);
        bus.res_valid      = (state == DONE);
        bus.buf_read_en    = beat;
        bus.buf_write_en   = beat;
        bus.wgt_ready      = beat;
        bus.buf_write_data = beat ? bus.buf_read_data : '0;
        bus.qnt_data_in    = acc;
        bus.res_data       = res_data_r;
        bus.res_error      = res_error_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r       <= '0;
            count       <= '0;
            offset_r    <= '0;
            acc         <= '0;
            tmo         <= '0;
            res_data_r  <= '0;
            res_error_r <= 1'b0;
        end else if (bus.abort) begin
            acc         <= '0;
            count       <= '0;
            tmo         <= '0;
            res_error_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        len_r    <= bus.start_len;
                        offset_r <= bus.offset;
                        acc      <= '0;
                        count    <= '0;
                    end
                end
                RUN: begin
                    if (beat) begin
                        acc   <= acc + dot4(bus.buf_read_data, bus.wgt_data, offset_r);
                        count <= count + LEN_W'(1);
                    end
                end
                QSTART: tmo <= '0;
                QWAIT: begin
                    // Status in the QSTART cycle is never looked at; sampling starts here.
                    if (bus.qnt_status) begin
                        res_data_r  <= bus.qnt_out;
                        res_error_r <= 1'b0;
                    end else if (tmo_hit) begin
                        res_data_r  <= '0;
                        res_error_r <= 1'b1;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cfu_mac_sequencer.sv
// Randomized bench for cfu_mac_sequencer with buffer, weight-stream and quantizer models
// and a lane-arithmetic reference for the accumulated dot product.
module tb_cfu_mac_sequencer;
    localparam int LEN_W       = 9;
    localparam int QNT_TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cfu_mac_sequencer_if #(.LEN_W(LEN_W)) bus();

    cfu_mac_sequencer #(.LEN_W(LEN_W), .QNT_TIMEOUT(QNT_TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int unsigned buf_q[$];
    int unsigned wgt_arr[$];
    int          widx;
    int          wmode;
    int          bmode;
    int          cyc = 0;

    bit          q_pend;
    int          q_cnt;
    int          q_delay;
    bit          q_const;
    bit          q_noise;

    bit          track;
    bit          running;
    int          exp_len;
    int          pops;
    int          qstarts;
    int          qs_due;
    int          qs_cyc;
    logic [31:0] q_cap;
    bit          res_seen;
    int          res_cyc;
    logic [31:0] res_d0;
    logic        res_e0;
    bit          accepted;
    int          acc_cyc;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int model_dot(input int unsigned a, input int unsigned w, input int off);
        int  s;
        byte ai;
        byte wi;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            ai = byte'(a >> (8 * i));
            wi = byte'(w >> (8 * i));
            s += (int'(ai) + off) * int'(wi);
        end
        return s;
    endfunction

    // One clock: drive at posedge+1, observe at posedge+2, update environment models.
    task automatic cycle(input bit sv, input bit ab, input bit rr);
        bit wv;
        bit exp_beat;
        @(posedge clk);
        #1;
        cyc++;
        bus.start_valid    = sv;
        bus.abort          = ab;
        bus.res_ready      = rr;
        bus.buf_read_valid = (buf_q.size() > 0) && (bmode == 0 || $urandom_range(0, 1) == 1);
        bus.buf_read_data  = (buf_q.size() > 0) ? buf_q[0] : $urandom;
        case (wmode)
            0:       wv = 1'b1;
            1:       wv = cyc[0];
            default: wv = ($urandom_range(0, 1) == 1);
        endcase
        bus.wgt_valid  = (widx < wgt_arr.size()) && wv;
        bus.wgt_data   = (widx < wgt_arr.size()) ? wgt_arr[widx] : $urandom;
        bus.qnt_status = 1'b0;
        if (q_pend) begin
            q_cnt--;
            if (q_cnt == 0) begin
                bus.qnt_status = 1'b1;
                q_pend = 1'b0;
            end
        end else if (q_noise && cyc == qs_due) begin
            bus.qnt_status = 1'b1;
        end
        #1;
        exp_beat = track && running && bus.buf_read_valid && bus.wgt_valid && !ab;
        if (track) begin
            check_eq("buf_read_en", bus.buf_read_en, exp_beat);
            check_eq("qnt_start", bus.qnt_start, cyc == qs_due);
        end
        if (bus.buf_read_en) begin
            check_eq("buf_write_en", bus.buf_write_en, 1);
            check_eq("wgt_ready", bus.wgt_ready, 1);
            if (buf_q.size() > 0) begin
                check_eq("buf_write_data", bus.buf_write_data, buf_q[0]);
                buf_q.push_back(buf_q.pop_front());
            end
            widx++;
            pops++;
            if (track && pops == exp_len) begin
                running = 1'b0;
                qs_due  = cyc + 1;
            end
        end
        if (bus.qnt_start) begin
            qstarts++;
            qs_cyc = cyc;
            q_cap  = bus.qnt_data_in;
            bus.qnt_out = q_const ? 32'h7 : bus.qnt_data_in + 32'd1;
            if (q_delay > 0) begin
                q_pend = 1'b1;
                q_cnt  = q_delay;
            end
        end
        if (track && sv && bus.start_ready) begin
            running = (exp_len > 0);
            if (exp_len == 0) qs_due = cyc + 1;
        end
        if (bus.res_valid) begin
            if (!res_seen) begin
                res_seen = 1'b1;
                res_cyc  = cyc;
                res_d0   = bus.res_data;
                res_e0   = bus.res_error;
            end else begin
                check_eq("res_data_stable", bus.res_data, res_d0);
                check_eq("res_error_stable", bus.res_error, res_e0);
            end
            if (rr && !accepted) begin
                accepted = 1'b1;
                acc_cyc  = cyc;
            end
        end
    endtask

    task automatic run_op(input int len, input int off, input bit fixed,
                          input int unsigned a_fix, input int unsigned w_fix,
                          input int wm, input int bm, input int qd, input int hold,
                          input bit qc, input bit noise);
        int exp_acc;
        int budget;
        int exp_lat;
        bit rr;
        buf_q.delete();
        wgt_arr.delete();
        for (int i = 0; i < len; i++) begin
            buf_q.push_back(fixed ? a_fix : $urandom);
            wgt_arr.push_back(fixed ? w_fix : $urandom);
        end
        if (len == 0) begin
            buf_q.push_back($urandom);
            buf_q.push_back($urandom);
        end
        exp_acc = 0;
        for (int i = 0; i < len; i++) exp_acc += model_dot(buf_q[i], wgt_arr[i], off);
        wmode = wm; bmode = bm; widx = 0;
        q_delay = qd; q_const = qc; q_noise = noise; q_pend = 1'b0;
        pops = 0; qstarts = 0; exp_len = len; running = 1'b0; qs_due = -10;
        res_seen = 1'b0; accepted = 1'b0; acc_cyc = 0; track = 1'b1;
        bus.start_len = LEN_W'(len);
        bus.offset    = off;
        cycle(1'b1, 1'b0, 1'b0);
        budget = len * 8 + QNT_TIMEOUT + 40;
        while (!accepted && budget > 0) begin
            rr = ((res_seen ? (cyc + 1 - res_cyc) : 0) >= hold);
            cycle(1'b0, 1'b0, rr);
            budget--;
        end
        track = 1'b0;
        check_eq("op_completed", accepted, 1);
        check_eq("pop_count", pops, len);
        check_eq("qnt_start_count", qstarts, 1);
        check_eq("qnt_data_in", q_cap, 32'(exp_acc));
        check_eq("res_error", res_e0, qd < 0);
        check_eq("res_data", res_d0, (qd < 0) ? 32'd0 : (qc ? 32'd7 : 32'(exp_acc + 1)));
        exp_lat = (qd < 0) ? QNT_TIMEOUT + 1 : qd + 1;
        check_eq("res_latency", res_cyc - qs_cyc, exp_lat);
        check_eq("res_hold", acc_cyc - res_cyc, hold);
        cycle(1'b0, 1'b0, 1'b0);
        check_eq("idle_start_ready", bus.start_ready, 1);
        check_eq("idle_busy", bus.busy, 0);
        check_eq("idle_res_valid", bus.res_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_valid = 0; bus.start_len = '0; bus.offset = '0; bus.abort = 0;
        bus.buf_read_valid = 0; bus.buf_read_data = '0; bus.wgt_valid = 0; bus.wgt_data = '0;
        bus.qnt_status = 0; bus.qnt_out = '0; bus.res_ready = 0;
        track = 0; wmode = 0; bmode = 0; widx = 0; q_pend = 0; q_delay = -1;
        q_const = 0; q_noise = 0; qs_due = -10; res_seen = 0; accepted = 0;
        #2;
        check_eq("rst_start_ready", bus.start_ready, 1);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_res_valid", bus.res_valid, 0);
        check_eq("rst_qnt_start", bus.qnt_start, 0);
        check_eq("rst_qnt_data_in", bus.qnt_data_in, 0);
        check_eq("rst_res_data", bus.res_data, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Directed cases
        run_op(3, 0, 1, 32'h01010101, 32'h02020202, 0, 0, 3, 0, 0, 0);
        check_eq("t1_acc", q_cap, 24);
        check_eq("t1_res", res_d0, 25);
        run_op(1, 128, 1, 32'h01010101, 32'h02020202, 0, 0, 2, 0, 0, 0);
        check_eq("t2_acc", q_cap, 1032);
        run_op(4, $urandom, 0, 0, 0, 1, 0, 2, 0, 0, 1);
        run_op(0, 5, 0, 0, 0, 0, 0, 4, 0, 1, 0);
        check_eq("t4_res", res_d0, 7);
        run_op(2, -3, 0, 0, 0, 0, 0, -1, 5, 0, 1);
        run_op(2, 7, 1, 32'h80808080, 32'h80808080, 0, 0, 1, 0, 0, 1);
        run_op(511, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // Randomized operations
        for (int n = 0; n < 12; n++) begin
            run_op($urandom_range(0, 12),
                   ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 255)) - 128,
                   0, 0, 0, $urandom_range(0, 2), $urandom_range(0, 1),
                   $urandom_range(1, 6), $urandom_range(0, 3), 0, $urandom_range(0, 1));
        end

        // Abort on the second beat of a len=5 op
        buf_q.delete(); wgt_arr.delete();
        for (int i = 0; i < 5; i++) begin
            buf_q.push_back($urandom);
            wgt_arr.push_back($urandom);
        end
        wmode = 0; bmode = 0; widx = 0; pops = 0; track = 0; q_delay = -1; q_noise = 0;
        bus.start_len = LEN_W'(5); bus.offset = 3;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check_eq("abort_first_pop", pops, 1);
        cycle(1'b0, 1'b1, 1'b0);
        check_eq("abort_beat_no_pop", bus.buf_read_en, 0);
        check_eq("abort_wgt_ready", bus.wgt_ready, 0);
        cycle(1'b0, 1'b0, 1'b0);
        check_eq("abort_pop_total", pops, 1);
        check_eq("abort_idle", bus.start_ready, 1);
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_acc_clear", bus.qnt_data_in, 0);

        // Async reset while waiting on the quantizer
        buf_q.delete(); wgt_arr.delete();
        buf_q.push_back(32'h01010101);
        wgt_arr.push_back(32'h02020202);
        widx = 0; pops = 0; q_delay = -1;
        bus.start_len = LEN_W'(1); bus.offset = 0;
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
        check_eq("pre_rst_busy", bus.busy, 1);
        check_eq("pre_rst_acc", bus.qnt_data_in, 8);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_start_ready", bus.start_ready, 1);
        check_eq("arst_busy", bus.busy, 0);
        check_eq("arst_qnt_start", bus.qnt_start, 0);
        check_eq("arst_qnt_data_in", bus.qnt_data_in, 0);
        check_eq("arst_res_valid", bus.res_valid, 0);
        check_eq("arst_res_data", bus.res_data, 0);
        check_eq("arst_res_error", bus.res_error, 0);
        check_eq("arst_buf_read_en", bus.buf_read_en, 0);
        @(posedge clk); #1; rst = 1'b0;
        q_pend = 0;
        run_op(2, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
